// File: rtl/edge_rate_counter.sv
// edge_rate_counter
//   Measures the rate and duty cycle of an asynchronous 1-bit stream (such as
//   the MSB of a phase-accumulator NCO) over a gate window of 2^GATE_LOG2
//   clocks. At the end of each window it publishes the rising-edge count and
//   the number of cycles the stream was high, together with a one-cycle strobe.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   din        asynchronous serial bit stream
//   enable     1 = measure continuously, 0 = idle with accumulators cleared
//   count_out  rising edges seen in the last completed window (saturating)
//   high_out   cycles with synchronized din = 1 in the last completed window
//   valid      single-cycle strobe: count_out/high_out just updated
//   overflow   last completed window saturated the edge counter
module edge_rate_counter #(
  parameter int GATE_LOG2   = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic [GATE_LOG2:0]   high_out,
  output logic                 valid,
  output logic                 overflow
);

  localparam int HW = GATE_LOG2 + 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   p;

  logic [GATE_LOG2-1:0]   gate;
  logic [CNT_WIDTH-1:0]   edge_acc;
  logic [HW-1:0]          high_acc;
  logic                   ovf_acc;

  logic                   rise;
  logic                   edge_sat;
  logic                   edge_blocked;
  logic                   terminal;
  logic [CNT_WIDTH-1:0]   edge_next;
  logic [HW-1:0]          high_next;

  assign s = sync[SYNC_STAGES-1];

  // Synchronizer and previous-sample flop run regardless of enable, so that
  // enabling while din is already high does not register a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      p    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      p    <= s;
    end
  end

  always_comb begin
    rise         = s & ~p;
    edge_sat     = &edge_acc;
    edge_blocked = rise & edge_sat;
    edge_next    = edge_acc;
    if (rise && !edge_sat) begin
      edge_next = edge_acc + CNT_WIDTH'(1);
    end
    high_next    = high_acc + HW'(s);
    terminal     = enable & (&gate);
  end

  // The terminal cycle folds in its own sample before publishing, so the
  // next window begins immediately with cleared accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate      <= '0;
      edge_acc  <= '0;
      high_acc  <= '0;
      ovf_acc   <= 1'b0;
      count_out <= '0;
      high_out  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else if (!enable) begin
      gate      <= '0;
      edge_acc  <= '0;
      high_acc  <= '0;
      ovf_acc   <= 1'b0;
      valid     <= 1'b0;
    end else begin
      gate <= gate + GATE_LOG2'(1);
      if (terminal) begin
        count_out <= edge_next;
        high_out  <= high_next;
        overflow  <= ovf_acc | edge_blocked;
        valid     <= 1'b1;
        edge_acc  <= '0;
        high_acc  <= '0;
        ovf_acc   <= 1'b0;
      end else begin
        edge_acc  <= edge_next;
        high_acc  <= high_next;
        ovf_acc   <= ovf_acc | edge_blocked;
        valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_rate_counter.sv
module tb_edge_rate_counter;

  localparam int G    = 4;
  localparam int WIN  = 16;
  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       enable;
  logic [7:0] count8;
  logic [4:0] high8;
  logic       valid8;
  logic       ovf8;
  logic [2:0] count3;
  logic [4:0] high3;
  logic       valid3;
  logic       ovf3;

  edge_rate_counter #(.GATE_LOG2(G), .CNT_WIDTH(8), .SYNC_STAGES(SYNC)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .enable(enable),
    .count_out(count8), .high_out(high8), .valid(valid8), .overflow(ovf8)
  );

  edge_rate_counter #(.GATE_LOG2(G), .CNT_WIDTH(3), .SYNC_STAGES(SYNC)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .enable(enable),
    .count_out(count3), .high_out(high3), .valid(valid3), .overflow(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int c;
    int h;
    int o;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];

  // Reference model: s is din as sampled SYNC edges earlier; a window is the
  // list of s values over WIN consecutive enabled cycles, plus the s value
  // just before it so a rise at the first position can be judged.
  bit d_hist[$];
  bit win[$];
  bit last_s = 1'b0;

  always @(posedge clk) begin
    bit   s;
    int   rises;
    int   highs;
    exp_t e;
    if (!rst_n) begin
      d_hist.delete();
      win.delete();
      last_s = 1'b0;
      q8.delete();
      q3.delete();
    end else begin
      s = (d_hist.size() >= SYNC) ? d_hist[SYNC-1] : 1'b0;
      if (enable) begin
        if (win.size() == 0) win.push_back(last_s);
        win.push_back(s);
        if (win.size() == WIN + 1) begin
          rises = 0;
          highs = 0;
          for (int i = 1; i <= WIN; i++) begin
            if (win[i] && !win[i-1]) rises++;
            if (win[i]) highs++;
          end
          e.h = highs;
          e.c = (rises > 255) ? 255 : rises;
          e.o = (rises > 255) ? 1 : 0;
          q8.push_back(e);
          e.c = (rises > 7) ? 7 : rises;
          e.o = (rises > 7) ? 1 : 0;
          q3.push_back(e);
          win.delete();
        end
      end else begin
        win.delete();
      end
      last_s = s;
      d_hist.push_front(din);
      while (d_hist.size() > SYNC) void'(d_hist.pop_back());
    end
  end

  // Monitors: pop an expectation whenever one is due, and require that the
  // outputs hold their last published values between strobes.
  exp_t last8 = '{0, 0, 0};
  exp_t last3 = '{0, 0, 0};
  int   v8cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   had;
    if (!rst_n) begin
      last8 = '{0, 0, 0};
      last3 = '{0, 0, 0};
      q8.delete();
      q3.delete();
    end else begin
      had = (q8.size() > 0);
      if (had) e = q8.pop_front();
      chk("valid8", int'(valid8), int'(had));
      if (valid8) v8cnt++;
      if (valid8 && had) begin
        chk("count8", int'(count8), e.c);
        chk("high8", int'(high8), e.h);
        chk("ovf8", int'(ovf8), e.o);
        last8 = e;
      end else if (!valid8) begin
        chk("hold_count8", int'(count8), last8.c);
        chk("hold_high8", int'(high8), last8.h);
        chk("hold_ovf8", int'(ovf8), last8.o);
      end

      had = (q3.size() > 0);
      if (had) e = q3.pop_front();
      chk("valid3", int'(valid3), int'(had));
      if (valid3 && had) begin
        chk("count3", int'(count3), e.c);
        chk("high3", int'(high3), e.h);
        chk("ovf3", int'(ovf3), e.o);
        last3 = e;
      end else if (!valid3) begin
        chk("hold_count3", int'(count3), last3.c);
        chk("hold_high3", int'(high3), last3.h);
        chk("hold_ovf3", int'(ovf3), last3.o);
      end
    end
  end

  int ph = 0;

  // mode: 0 din=0, 1 din=1, 2 square 2 high/2 low, 3 toggle each cycle, 4 random
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       din = 1'b0;
        1:       din = 1'b1;
        2:       din = ((ph % 4) < 2);
        3:       din = ((ph % 2) == 0);
        default: din = 1'($urandom_range(0, 1));
      endcase
      ph++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count8"}, int'(count8), 0);
    chk({tag, "_high8"}, int'(high8), 0);
    chk({tag, "_valid8"}, int'(valid8), 0);
    chk({tag, "_ovf8"}, int'(ovf8), 0);
    chk({tag, "_count3"}, int'(count3), 0);
    chk({tag, "_high3"}, int'(high3), 0);
    chk({tag, "_valid3"}, int'(valid3), 0);
    chk({tag, "_ovf3"}, int'(ovf3), 0);
  endtask

  initial begin
    int vstart;
    rst_n  = 1'b0;
    enable = 1'b0;
    din    = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_zero("reset");
    run(4, 0);

    // Quiet input: three windows, all zero.
    enable = 1'b1;
    vstart = v8cnt;
    run(48, 0);
    @(negedge clk);
    #1 chk("valids_in_48", v8cnt - vstart, 3);

    // din high before enable: no spurious edge.
    enable = 1'b0;
    run(3, 1);
    enable = 1'b1;
    run(32, 1);

    // Settled square wave, then overflow and recovery.
    run(64, 2);
    run(32, 3);
    run(32, 0);

    // Drop enable at gate=9 for 5 cycles.
    enable = 1'b0;
    run(2, 2);
    enable = 1'b1;
    run(9, 2);
    enable = 1'b0;
    vstart = v8cnt;
    run(5, 2);
    enable = 1'b1;
    run(15, 2);
    @(negedge clk);
    #1 chk("no_valid_gap", v8cnt - vstart, 0);
    run(1, 2);
    @(negedge clk);
    #1 chk("valid_16_after_reenable", v8cnt - vstart, 1);

    // Asynchronous reset at gate=7, between clock edges.
    enable = 1'b0;
    run(1, 2);
    enable = 1'b1;
    run(7, 2);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    run(2, 2);
    #1 rst_n = 1'b1;
    vstart = v8cnt;
    run(15, 2);
    @(negedge clk);
    #1 chk("no_valid_after_reset", v8cnt - vstart, 0);
    run(1, 2);
    @(negedge clk);
    #1 chk("valid_16_after_reset", v8cnt - vstart, 1);

    // Randomized mix of patterns and enable gaps.
    for (int b = 0; b < 40; b++) begin
      enable = ($urandom_range(0, 7) != 0);
      run($urandom_range(1, 40), $urandom_range(0, 4));
    end

    enable = 1'b0;
    run(3, 0);
    chk("q8_drained", q8.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
